rv_muldiv: RTL and testbench

- Iterative multiply/divide unit implementing the RV M-extension operations, parametrised in datapath width.
- Successor to the single-cycle combinational ALU: same operand/op-select/result/zero style, plus valid/ready handshake, multi-cycle state machine, signed/unsigned variants, word mode and abort.
- Sits beside the ALU in EX. The pipeline stalls on ready_o low and consumes the result on the valid_o pulse.

---
 rtl/rv_muldiv.sv | 170 +++++++++++++++++
 tb/tb_rv_muldiv.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv.sv
// Iterative RV M-extension multiply/divide unit. Each cycle handles one bit:
// shift-add multiply or restoring divide on operand magnitudes, with the sign fixed up at the end.
module rv_muldiv #(
  parameter int XLEN      = 64,
  parameter bit SUPPORT_W = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [2:0]      op_sel_i,
  input  logic            word_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);
  localparam int PW      = 2 * XLEN;
  localparam int CW      = $clog2(XLEN + 1);
  localparam bit WORD_OK = SUPPORT_W && (XLEN == 64);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_word, r_neg_res, r_neg_rem, r_special;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_a;   // multiplicand shifting left, or divisor in the low half
  logic [PW-1:0]   r_p;   // product accumulator, partial remainder, or resolved special result
  logic [XLEN-1:0] r_b;   // multiplier shifting right, or dividend turning into quotient

  // Extend a 32-bit value to XLEN; this form stays legal when XLEN is 32.
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    return XLEN'(v) | ((sgn && v[31]) ? ~XLEN'(32'hFFFF_FFFF) : '0);
  endfunction

  logic            w_word, w_op1_signed, w_op2_signed, w_neg_a, w_neg_b;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a, w_b, w_mag_a, w_mag_b, w_min_neg, w_special_res;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_word       = WORD_OK && word_i;
    w_op1_signed = op_sel_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    w_op2_signed = op_sel_i inside {3'b000, 3'b001, 3'b100, 3'b110};
    w_a          = op1_i;
    w_b          = op2_i;
    w_min_neg    = {1'b1, {(XLEN-1){1'b0}}};
    if (w_word) begin
      w_a       = ext32(op1_i[31:0], w_op1_signed);
      w_b       = ext32(op2_i[31:0], w_op2_signed);
      w_min_neg = ~XLEN'(32'h7FFF_FFFF);
    end
    w_neg_a   = w_op1_signed && w_a[XLEN-1];
    w_neg_b   = w_op2_signed && w_b[XLEN-1];
    w_mag_a   = w_neg_a ? -w_a : w_a;
    w_mag_b   = w_neg_b ? -w_b : w_b;
    w_div0    = (w_b == '0);
    w_ovf     = (op_sel_i inside {3'b100, 3'b110}) && (w_a == w_min_neg) && (w_b == '1);
    w_special = op_sel_i[2] && (w_div0 || w_ovf);
    if (w_div0) w_special_res = op_sel_i[1] ? w_a : '1;
    else        w_special_res = op_sel_i[1] ? '0  : w_a;
  end

  logic [XLEN:0]   w_shift, w_rem_nxt;
  logic [XLEN+1:0] w_diff;
  logic            w_qbit;

  // One restoring-divide step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    w_shift   = {r_p[XLEN-1:0], r_b[XLEN-1]};
    w_diff    = {1'b0, w_shift} - {2'b00, r_a[XLEN-1:0]};
    w_qbit    = ~w_diff[XLEN+1];
    w_rem_nxt = w_qbit ? w_diff[XLEN:0] : w_shift;
  end

  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_quo, w_rem, w_hi, w_sel, w_res;

  always_comb begin
    w_prod = r_neg_res ? -r_p : r_p;
    w_quo  = r_neg_res ? -r_b : r_b;
    w_rem  = r_neg_rem ? -r_p[XLEN-1:0] : r_p[XLEN-1:0];
    w_hi   = r_word ? XLEN'(w_prod[63:32]) : w_prod[PW-1:XLEN];
    case (r_op)
      3'b000:                 w_sel = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_hi;
      3'b100, 3'b101:         w_sel = w_quo;
      default:                w_sel = w_rem;
    endcase
    if (r_special) w_sel = r_p[XLEN-1:0];
    w_res = r_word ? ext32(w_sel[31:0], 1'b1) : w_sel;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      result_o  <= '0;
      r_op      <= '0;
      r_word    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_special <= 1'b0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_p       <= '0;
      r_b       <= '0;
    end else begin
      valid_o <= 1'b0;
      if (kill_i) begin
        r_state <= S_IDLE;
        ready_o <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: if (valid_i) begin
            r_op      <= op_sel_i;
            r_word    <= w_word;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_special <= w_special;
            r_cnt     <= w_word ? CW'(32) : CW'(XLEN);
            ready_o   <= 1'b0;
            if (w_special) begin
              r_p     <= PW'(w_special_res);
              r_state <= S_DONE;
            end else begin
              r_p     <= '0;
              r_state <= S_CALC;
              if (op_sel_i[2]) begin
                // Left-align the dividend so the MSB-first step always reads bit XLEN-1.
                r_a <= PW'(w_mag_b);
                r_b <= w_word ? (w_mag_a << (XLEN - 32)) : w_mag_a;
              end else begin
                r_a <= PW'(w_mag_a);
                r_b <= w_mag_b;
              end
            end
          end
          S_CALC: begin
            if (r_op[2]) begin
              r_p <= PW'(w_rem_nxt);
              r_b <= {r_b[XLEN-2:0], w_qbit};
            end else begin
              if (r_b[0]) r_p <= r_p + r_a;
              r_a <= r_a << 1;
              r_b <= r_b >> 1;
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_DONE;
          end
          S_DONE: begin
            result_o <= w_res;
            valid_o  <= 1'b1;
            ready_o  <= 1'b1;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_rv_muldiv.sv
// Randomised bench for rv_muldiv (XLEN=64): a 128-bit arithmetic reference model feeds a
// scoreboard checked on every cycle, plus literal expectations that pin the model itself.
module tb_rv_muldiv;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n_i, valid_i, ready_o, word_i, kill_i, valid_o, zero_o;
  logic [63:0] op1_i, op2_i, result_o;
  logic [2:0]  op_sel_i;

  int     tests = 0;
  int     fails = 0;
  longint pcount = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    longint      t0;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_hold = '0;

  rv_muldiv #(.XLEN(64), .SUPPORT_W(1'b1)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .op_sel_i (op_sel_i),
    .word_i   (word_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcount <= pcount + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic in 128 bits on the N-bit interpretation of each operand.
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic w);
    exp_t               e;
    int                 n;
    logic [63:0]        am, bm, r;
    logic signed [127:0] x, y, p, q, rm;
    bit                 s1, s2, special;
    n  = w ? 32 : 64;
    am = w ? {32'b0, a[31:0]} : a;
    bm = w ? {32'b0, b[31:0]} : b;
    s1 = op inside {MUL, MULH, MULHSU, DIV, REM};
    s2 = op inside {MUL, MULH, DIV, REM};
    x  = {64'b0, am};
    y  = {64'b0, bm};
    if (s1 && am[n-1]) x = x - (128'sd1 << n);
    if (s2 && bm[n-1]) y = y - (128'sd1 << n);
    p = x * y;
    special = 0;
    q = 0;
    rm = 0;
    if (op[2]) begin
      if (y == 0) begin
        q = -1; rm = x; special = 1;
      end else if (s1 && s2 && x == -(128'sd1 << (n - 1)) && y == -1) begin
        q = x; rm = 0; special = 1;
      end else begin
        q = x / y; rm = x % y;
      end
    end
    case (op)
      MUL:                 r = p[63:0];
      MULH, MULHSU, MULHU: begin p = p >>> n; r = p[63:0]; end
      DIV, DIVU:           r = q[63:0];
      default:             r = rm[63:0];
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    e.res = r;
    e.lat = special ? 1 : n + 1;
    e.t0  = 0;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic w, input bit push);
    exp_t e;
    for (int t = 0; t < 300 && !ready_o; t++) @(negedge clk);
    if (!ready_o) check("ready_timeout", {63'b0, ready_o}, 64'd1);
    valid_i  = 1'b1;
    op_sel_i = op;
    op1_i    = a;
    op2_i    = b;
    word_i   = w;
    e        = model(op, a, b, w);
    e.t0     = pcount;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic w, input logic [63:0] exp_res,
                          input int exp_lat);
    exp_t m;
    m = model(op, a, b, w);
    check({name, "_model_res"}, m.res, exp_res);
    check({name, "_model_lat"}, 64'(m.lat), 64'(exp_lat));
    issue(op, a, b, w, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return '1;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'hFFFF_FFFF_8000_0000;
      5:       return 64'($urandom_range(0, 40));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Scoreboard: every valid_o must match the oldest expectation, and the held result must persist.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n_i) begin
      exp_hold = '0;
    end else begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {63'b0, valid_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", result_o, e.res);
          check("latency", 64'(pcount - e.t0 - 1), 64'(e.lat));
          exp_hold = e.res;
        end
      end
      check("result_hold", result_o, exp_hold);
      check("zero", {63'b0, zero_o}, {63'b0, exp_hold == 64'd0});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_i  = 1'b0;
    valid_i  = 1'b0;
    kill_i   = 1'b0;
    word_i   = 1'b0;
    op_sel_i = '0;
    op1_i    = '0;
    op2_i    = '0;
    @(negedge clk);
    check("rst_ready", {63'b0, ready_o}, 64'd1);
    check("rst_valid", {63'b0, valid_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_zero", {63'b0, zero_o}, 64'd1);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);

    directed("mulhu_max", MULHU, '1, '1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    directed("mulh_neg", MULH, -64'sd3, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    directed("mul_neg", MUL, -64'sd3, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    directed("div_neg", DIV, -64'sd7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    directed("rem_neg", REM, -64'sd7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    directed("divu", DIVU, 64'd20, 64'd6, 1'b0, 64'd3, 65);
    directed("remu", REMU, 64'd20, 64'd6, 1'b0, 64'd2, 65);
    directed("divu_by0", DIVU, 64'd123, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed("rem_by0", REM, 64'd5, 64'd0, 1'b0, 64'd5, 1);
    directed("div_ovf", DIV, 64'h8000_0000_0000_0000, '1, 1'b0, 64'h8000_0000_0000_0000, 1);
    directed("rem_ovf", REM, 64'h8000_0000_0000_0000, '1, 1'b0, 64'd0, 1);
    directed("mulw_sext", MUL, 64'h0000_0000_8000_0000, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 33);
    directed("divw_ovf", DIV, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1,
             64'hFFFF_FFFF_8000_0000, 1);
    directed("remuw_by0", REMU, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 1'b1,
             64'hFFFF_FFFF_9ABC_DEF0, 1);
    drain();

    // Kill in CALC: the aborted op must never strobe, and the unit must be free next cycle.
    issue(MUL, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_ready", {63'b0, ready_o}, 64'd1);
    check("kill_no_valid", {63'b0, valid_o}, 64'd0);
    directed("mul_after_kill", MUL, 64'd6, 64'd7, 1'b0, 64'd42, 65);
    drain();

    // Reset mid-CALC: outputs return to reset values immediately, without waiting for a clock.
    issue(DIVU, {$urandom, $urandom}, 64'd3, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n_i = 1'b0;
    #1;
    check("midrst_ready", {63'b0, ready_o}, 64'd1);
    check("midrst_valid", {63'b0, valid_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_zero", {63'b0, zero_o}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (80) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      issue(op, pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
